// File: rtl/sprite_buffer.sv
// Per-scanline sprite buffer: captures up to MAX_SPRITES visible sprites during OAM scan and
// reports, one tick after each query, the lowest-slot sprite whose fetch must start at the current pixel.
module sprite_buffer #(
  parameter int MAX_SPRITES = 10,
  parameter int NUM_SPRITES = 40
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           tick_in,
  input  logic                           scan_start_in,
  input  logic                           add_valid_in,
  input  logic [$clog2(NUM_SPRITES)-1:0] add_index_in,
  input  logic [7:0]                     add_x_in,
  input  logic                           query_en_in,
  input  logic [7:0]                     pixel_x_in,
  input  logic                           fetch_done_in,
  output logic [3:0]                     count_out,
  output logic                           full_out,
  output logic                           overflow_out,
  output logic                           hit_out,
  output logic [3:0]                     hit_slot_out,
  output logic [$clog2(NUM_SPRITES)-1:0] hit_index_out,
  output logic [7:0]                     hit_x_out
);

  localparam int          IW      = $clog2(NUM_SPRITES);
  localparam logic [3:0]  MAX_CNT = 4'(MAX_SPRITES);

  logic [IW-1:0] slot_index [MAX_SPRITES];
  logic [7:0]    slot_x     [MAX_SPRITES];
  logic          slot_valid [MAX_SPRITES];
  logic          slot_done  [MAX_SPRITES];

  logic          ack;
  logic          any_match;
  logic [3:0]    sel_slot;
  logic [IW-1:0] sel_index;
  logic [7:0]    sel_x;

  assign ack      = fetch_done_in & hit_out;
  assign full_out = (count_out == MAX_CNT);

  // Lowest matching slot wins; the slot being acknowledged this tick is already treated as done.
  always_comb begin
    any_match = 1'b0;
    sel_slot  = '0;
    sel_index = '0;
    sel_x     = '0;
    for (int i = MAX_SPRITES - 1; i >= 0; i--) begin
      if (slot_valid[i] && !slot_done[i] && !(ack && hit_slot_out == 4'(i)) &&
          ({1'b0, slot_x[i]} <= ({1'b0, pixel_x_in} + 9'd8))) begin
        any_match = 1'b1;
        sel_slot  = 4'(i);
        sel_index = slot_index[i];
        sel_x     = slot_x[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        slot_valid[i] <= 1'b0;
        slot_done[i]  <= 1'b0;
        slot_index[i] <= '0;
        slot_x[i]     <= '0;
      end
      count_out     <= '0;
      overflow_out  <= 1'b0;
      hit_out       <= 1'b0;
      hit_slot_out  <= '0;
      hit_index_out <= '0;
      hit_x_out     <= '0;
    end else if (tick_in) begin
      if (scan_start_in) begin
        // New line: clear first, then a coincident add lands in slot 0.
        for (int i = 0; i < MAX_SPRITES; i++) begin
          slot_valid[i] <= 1'b0;
          slot_done[i]  <= 1'b0;
        end
        overflow_out <= 1'b0;
        hit_out      <= 1'b0;
        if (add_valid_in) begin
          slot_index[0] <= add_index_in;
          slot_x[0]     <= add_x_in;
          slot_valid[0] <= 1'b1;
          count_out     <= 4'd1;
        end else begin
          count_out <= '0;
        end
      end else begin
        for (int i = 0; i < MAX_SPRITES; i++) begin
          if (ack && hit_slot_out == 4'(i)) begin
            slot_done[i] <= 1'b1;
          end
          if (add_valid_in && count_out == 4'(i)) begin
            slot_index[i] <= add_index_in;
            slot_x[i]     <= add_x_in;
            slot_valid[i] <= 1'b1;
            slot_done[i]  <= 1'b0;
          end
        end
        if (add_valid_in) begin
          if (count_out < MAX_CNT) begin
            count_out <= count_out + 4'd1;
          end else begin
            overflow_out <= 1'b1;
          end
        end
        if (query_en_in && any_match) begin
          hit_out       <= 1'b1;
          hit_slot_out  <= sel_slot;
          hit_index_out <= sel_index;
          hit_x_out     <= sel_x;
        end else begin
          hit_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_buffer.sv
// Scoreboard bench for sprite_buffer: stimulus pushes expected outputs from a queue-based line model,
// a monitor pops and compares one entry after every clock edge.
module tb_sprite_buffer;

  localparam int MAX_SPRITES = 10;
  localparam int NUM_SPRITES = 40;

  typedef struct {
    logic [5:0] idx;
    logic [7:0] x;
    bit         done;
  } sprite_t;

  typedef struct {
    logic [3:0] cnt;
    logic       full;
    logic       ovf;
    logic       hit;
    logic [3:0] slot;
    logic [5:0] idx;
    logic [7:0] x;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       tick_in;
  logic       scan_start_in;
  logic       add_valid_in;
  logic [5:0] add_index_in;
  logic [7:0] add_x_in;
  logic       query_en_in;
  logic [7:0] pixel_x_in;
  logic       fetch_done_in;
  logic [3:0] count_out;
  logic       full_out;
  logic       overflow_out;
  logic       hit_out;
  logic [3:0] hit_slot_out;
  logic [5:0] hit_index_out;
  logic [7:0] hit_x_out;

  sprite_t line_q[$];
  bit         mdl_ovf;
  bit         mdl_hit;
  int         mdl_slot;
  logic [5:0] mdl_idx;
  logic [7:0] mdl_x;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  sprite_buffer #(.MAX_SPRITES(MAX_SPRITES), .NUM_SPRITES(NUM_SPRITES)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .scan_start_in(scan_start_in),
    .add_valid_in(add_valid_in), .add_index_in(add_index_in), .add_x_in(add_x_in),
    .query_en_in(query_en_in), .pixel_x_in(pixel_x_in), .fetch_done_in(fetch_done_in),
    .count_out(count_out), .full_out(full_out), .overflow_out(overflow_out), .hit_out(hit_out),
    .hit_slot_out(hit_slot_out), .hit_index_out(hit_index_out), .hit_x_out(hit_x_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic mdl_reset();
    line_q.delete();
    mdl_ovf  = 0;
    mdl_hit  = 0;
    mdl_slot = 0;
    mdl_idx  = '0;
    mdl_x    = '0;
  endtask

  // Line model: a list of sprites in scan order; acknowledged ones are marked done before searching.
  task automatic mdl_step(input bit tick, input bit ss, input bit add, input logic [5:0] idx,
                          input logic [7:0] x, input bit q, input logic [7:0] px, input bit fd);
    sprite_t s;
    sprite_t t;
    int found;
    if (!tick) return;
    s.idx = idx; s.x = x; s.done = 0;
    if (ss) begin
      line_q.delete();
      mdl_ovf = 0;
      mdl_hit = 0;
      if (add) line_q.push_back(s);
      return;
    end
    if (fd && mdl_hit) begin
      t = line_q[mdl_slot];
      t.done = 1;
      line_q[mdl_slot] = t;
    end
    found = -1;
    for (int i = 0; i < line_q.size(); i++) begin
      if (!line_q[i].done && int'(line_q[i].x) <= int'(px) + 8) begin
        found = i;
        break;
      end
    end
    if (add) begin
      if (line_q.size() < MAX_SPRITES) line_q.push_back(s);
      else mdl_ovf = 1;
    end
    if (q && found >= 0) begin
      mdl_hit  = 1;
      mdl_slot = found;
      mdl_idx  = line_q[found].idx;
      mdl_x    = line_q[found].x;
    end else begin
      mdl_hit = 0;
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit ss, input bit add, input logic [5:0] idx,
                               input logic [7:0] x, input bit q, input logic [7:0] px, input bit fd);
    exp_t e;
    @(negedge clk_in);
    tick_in       = tick;
    scan_start_in = ss;
    add_valid_in  = add;
    add_index_in  = idx;
    add_x_in      = x;
    query_en_in   = q;
    pixel_x_in    = px;
    fetch_done_in = fd;
    mdl_step(tick, ss, add, idx, x, q, px, fd);
    e.cnt  = 4'(line_q.size());
    e.full = (line_q.size() == MAX_SPRITES);
    e.ovf  = mdl_ovf;
    e.hit  = mdl_hit;
    e.slot = 4'(mdl_slot);
    e.idx  = mdl_idx;
    e.x    = mdl_x;
    exp_q.push_back(e);
  endtask

  task automatic do_scan(input bit add, input logic [5:0] idx, input logic [7:0] x);
    applyStimulus(1, 1, add, idx, x, 0, 8'd0, 0);
  endtask

  task automatic do_add(input logic [5:0] idx, input logic [7:0] x);
    applyStimulus(1, 0, 1, idx, x, 0, 8'd0, 0);
  endtask

  task automatic do_query(input logic [7:0] px, input bit fd);
    applyStimulus(1, 0, 0, 6'd0, 8'd0, 1, px, fd);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_count"}, 32'(count_out), 0);
    checkOutput({tag, "_full"}, 32'(full_out), 0);
    checkOutput({tag, "_overflow"}, 32'(overflow_out), 0);
    checkOutput({tag, "_hit"}, 32'(hit_out), 0);
    checkOutput({tag, "_hit_slot"}, 32'(hit_slot_out), 0);
    checkOutput({tag, "_hit_index"}, 32'(hit_index_out), 0);
    checkOutput({tag, "_hit_x"}, 32'(hit_x_out), 0);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("count", 32'(count_out), 32'(e.cnt));
        checkOutput("full", 32'(full_out), 32'(e.full));
        checkOutput("overflow", 32'(overflow_out), 32'(e.ovf));
        checkOutput("hit", 32'(hit_out), 32'(e.hit));
        checkOutput("hit_slot", 32'(hit_slot_out), 32'(e.slot));
        checkOutput("hit_index", 32'(hit_index_out), 32'(e.idx));
        checkOutput("hit_x", 32'(hit_x_out), 32'(e.x));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_in        = 1'b0;
    tick_in       = 1'b0;
    scan_start_in = 1'b0;
    add_valid_in  = 1'b0;
    add_index_in  = '0;
    add_x_in      = '0;
    query_en_in   = 1'b0;
    pixel_x_in    = '0;
    fetch_done_in = 1'b0;
    mdl_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Fill past capacity, then read back the stored order through acknowledged hits.
    do_scan(0, 6'd0, 8'd0);
    for (int k = 0; k < 12; k++) do_add(6'(k), 8'(10 + 3 * k));
    for (int k = 0; k < 12; k++) do_query(8'd159, 1);
    do_scan(0, 6'd0, 8'd0);

    // Basic match threshold and acknowledge.
    do_add(6'd5, 8'd20);
    do_query(8'd11, 0);
    do_query(8'd12, 0);
    do_query(8'd13, 1);
    for (int p = 14; p < 160; p++) do_query(8'(p), 0);

    // Equal X: lower slot first, then the other, then nothing.
    do_scan(0, 6'd0, 8'd0);
    do_add(6'd7, 8'd30);
    do_add(6'd2, 8'd30);
    do_query(8'd22, 0);
    do_query(8'd22, 1);
    do_query(8'd22, 1);
    do_query(8'd22, 0);

    // Left-edge sprite and a stored x of 0.
    do_scan(0, 6'd0, 8'd0);
    do_add(6'd3, 8'd4);
    do_query(8'd0, 0);
    do_query(8'd0, 1);
    do_add(6'd11, 8'd0);
    do_query(8'd0, 0);

    // Scan start with coincident add, then frozen ticks with busy inputs.
    do_scan(0, 6'd0, 8'd0);
    for (int k = 0; k < 4; k++) do_add(6'(20 + k), 8'(60 + k));
    do_query(8'd60, 0);
    applyStimulus(1, 1, 1, 6'd9, 8'd50, 1, 8'd159, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 1, 6'd33, 8'd1, 1, 8'd100, 1);
    do_query(8'd100, 0);
    do_query(8'd100, 1);

    // Asynchronous reset between edges with a live hit.
    do_scan(0, 6'd0, 8'd0);
    do_add(6'd1, 8'd40);
    do_add(6'd2, 8'd41);
    do_add(6'd3, 8'd42);
    do_query(8'd40, 0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    mdl_reset();
    @(negedge clk_in);
    rst_in = 1'b1;

    // Randomized lines.
    for (int line = 0; line < 20; line++) begin
      do_scan($urandom_range(0, 1) == 1, 6'($urandom_range(0, 39)), 8'($urandom_range(0, 167)));
      n = $urandom_range(0, 13);
      for (int k = 0; k < n; k++)
        applyStimulus($urandom_range(0, 7) != 0, 0, 1, 6'($urandom_range(0, 39)),
                      8'($urandom_range(0, 167)), 0, 8'd0, 0);
      for (int p = 0; p < 160; p++)
        applyStimulus($urandom_range(0, 7) != 0, 0, $urandom_range(0, 31) == 0,
                      6'($urandom_range(0, 39)), 8'($urandom_range(0, 167)),
                      $urandom_range(0, 15) != 0, 8'(p), $urandom_range(0, 1) == 1);
    end

    @(posedge clk_in);
    #3;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_buffer.md
Name: sprite_buffer

Overview:
- Sits directly downstream of the OAM scan stage in the pixel processing unit.
- During OAM scan it captures the OAM index and X coordinate of each sprite flagged visible on the current scanline, up to 10 per line (hardware limit).
- During Draw it is queried with the current pixel X and reports, one cycle later, the highest-priority pending sprite whose fetch must start now.
- The sprite fetcher acknowledges each reported sprite so it is never reported twice on the same line.

Parameters:
- MAX_SPRITES, 10, buffer depth (sprites per scanline).
- NUM_SPRITES, 40, OAM entries; sets index width $clog2(NUM_SPRITES)=6.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- tick_in  input  1  T-cycle enable strobe; all state updates, except reset, happen only on clk_in edges with tick_in=1.
- scan_start_in  input  1  start of OAM scan for a new line; clears buffer.
- add_valid_in  input  1  sprite qualifies (one-tick pulse from OAM scan).
- add_index_in  input  6  OAM index of the qualifying sprite.
- add_x_in  input  8  OAM X byte of the qualifying sprite.
- query_en_in  input  1  Draw phase active; enables matching.
- pixel_x_in  input  8  current screen pixel X (0..159).
- fetch_done_in  input  1  fetcher accepted the sprite in hit_slot_out.
- count_out  output  4  number of stored entries (0..10).
- full_out  output  1  count_out == MAX_SPRITES.
- overflow_out  output  1  sticky: an add was dropped this line.
- hit_out  output  1  a pending sprite matches.
- hit_slot_out  output  4  slot of the matching sprite.
- hit_index_out  output  6  OAM index of the matching sprite.
- hit_x_out  output  8  X byte of the matching sprite.

Behaviour:
- Storage: MAX_SPRITES entries {index[5:0], x[7:0], valid, done}. Slot order equals OAM scan order, which is also priority order (lowest slot wins).
- Reset (rst_in=0, async): all valid/done bits cleared; count_out=0, full_out=0, overflow_out=0, hit_out=0, hit_slot_out=0, hit_index_out=0, hit_x_out=0.
- scan_start_in tick: clear all valid/done bits, count=0, overflow=0, hit_out=0.
  - If add_valid_in is high on the same tick, the add is written to slot 0 and count becomes 1 (clear, then write).
- Add tick (add_valid_in=1, no scan_start):
  - If count < MAX_SPRITES: write slot[count] with valid=1, done=0; count += 1.
  - Else: drop the add; overflow_out <= 1; count unchanged.
- Match condition per slot: valid && !done && ({1'b0,x} <= {1'b0,pixel_x_in} + 9'd8), compared at 9 bits.
  - x < 8 (partially off the left edge) therefore matches at pixel 0.
  - x == 0 never reaches the buffer (OAM scan rejects it), but must still match harmlessly if stored.
- Hit register, one tick latency:
  - With query_en_in=1, each tick loads hit_out/slot/index/x from the lowest matching slot.
  - With no match, hit_out <= 0 and the other hit fields hold their last values.
  - With query_en_in=0, hit_out <= 0.
- Acknowledge: when fetch_done_in=1 on a tick where hit_out=1, set done for slot hit_slot_out.
  - That slot is excluded from the match evaluated on the same tick, so the next hit (if any) is a different slot.
  - fetch_done_in while hit_out=0 is ignored.
- Two sprites with equal X: both hit, on consecutive acknowledged ticks, lower slot first.
- Adds during query_en_in are still accepted (no gating); the integration owns phase sequencing.
- tick_in=0: all registers hold; outputs stable.

Test Plan:
- Reset mid-operation: store 3 sprites, assert rst_in=0 asynchronously between clk edges -> all outputs 0 immediately, count_out=0 with no clock edge required.
- Fill and overflow: scan_start, then 12 adds with indices 0..11 -> count_out=10, full_out=1, overflow_out=1, slots hold indices 0..9; next scan_start -> count_out=0, overflow_out=0.
- Basic match: add (idx 5, x=20), query with pixel_x=11 -> hit_out=0; pixel_x=12 -> hit_out=1, hit_index_out=5, hit_x_out=20 one tick later; fetch_done -> hit_out=0 next tick and stays 0 for pixel_x=13..159.
- Priority and equal X: adds (idx 7, x=30), (idx 2, x=30) -> at pixel_x=22, first hit is idx 7 (slot 0); after fetch_done, idx 2 (slot 1); after fetch_done, hit_out=0.
- Left-edge sprite: add (idx 3, x=4), query pixel_x=0 -> hit_out=1, hit_x_out=4.
- Simultaneous scan_start and add: buffer holds 4 entries, pulse scan_start_in with add (idx 9, x=50) -> count_out=1, slot 0 = idx 9, hit_out=0; tick_in held low for 5 clocks -> no state change.
